// File: rtl/vit_seq_ctrl.sv
// Viterbi decoder sequencing controller.
// Takes 16-bit received words (eight 2-bit symbols, MSB pair first) and feeds
// one symbol per cycle to the branch-metric unit. It also raises the ACS enable
// one cycle later, together with the trellis step index. At the end of a frame
// it runs the traceback handshake, with a timeout guard.
module vit_seq_ctrl #(
  parameter int FRAME_SYMS = 512,
  parameter int TB_TIMEOUT = 4096,
  localparam int CW = $clog2(FRAME_SYMS),
  localparam int TW = $clog2(TB_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_word,
  output logic          en_brch,
  output logic [1:0]    sym_rx,
  output logic          en_acs,
  output logic [CW-1:0] sym_idx,
  output logic          tb_start,
  input  logic          tb_done,
  output logic          frame_done,
  output logic          err_timeout,
  output logic          busy
);

  // Binary state encoding.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BRCH  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] TB    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // Index of the last symbol in a frame, and the last cycle of the traceback window.
  localparam logic [CW-1:0] LAST_SYM = CW'(FRAME_SYMS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TB_TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  // The shift register holds the symbols of the current word that are not yet
  // issued, left-aligned. The symbol on sym_rx has already been taken out.
  logic [15:0]   shift;
  logic [15:0]   shift_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_nxt;
  logic          en_brch_nxt;
  logic [1:0]    sym_rx_nxt;
  logic          tb_start_nxt;
  logic          frame_done_nxt;
  logic          err_nxt;
  logic          word_end;
  logic          accept;

  // The current symbol is the last one of its word.
  assign word_end = (cnt[2:0] == 3'd7);
  assign accept   = in_valid && in_ready;

  // Ready depends only on state and symbol count; it is held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    in_ready = 1'b1;
        WAIT:    in_ready = 1'b1;
        BRCH:    in_ready = word_end && (cnt != LAST_SYM);
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift;
    cnt_nxt        = cnt;
    to_nxt         = to_cnt;
    en_brch_nxt    = 1'b0;
    sym_rx_nxt     = 2'b00;
    tb_start_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    err_nxt        = err_timeout;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = BRCH;
          shift_nxt   = {in_word[13:0], 2'b00};
          sym_rx_nxt  = in_word[15:14];
          en_brch_nxt = 1'b1;
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      BRCH: begin
        if (cnt == LAST_SYM) begin
          // The final symbol is on the bus now, so its ACS step happens during FLUSH.
          state_nxt = FLUSH;
        end else if (word_end) begin
          cnt_nxt = cnt + CW'(1);
          if (accept) begin
            // Reload in the same cycle so back-to-back words leave no gap in en_brch.
            shift_nxt   = {in_word[13:0], 2'b00};
            sym_rx_nxt  = in_word[15:14];
            en_brch_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else begin
          shift_nxt   = {shift[13:0], 2'b00};
          sym_rx_nxt  = shift[15:14];
          en_brch_nxt = 1'b1;
          cnt_nxt     = cnt + CW'(1);
        end
      end
      WAIT: begin
        if (accept) begin
          state_nxt   = BRCH;
          shift_nxt   = {in_word[13:0], 2'b00};
          sym_rx_nxt  = in_word[15:14];
          en_brch_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      FLUSH: begin
        state_nxt    = TB;
        tb_start_nxt = 1'b1;
        to_nxt       = '0;
      end
      TB: begin
        // tb_done is ignored in the cycle that carries tb_start. tb_done wins over the timeout.
        if (!tb_start && tb_done) begin
          state_nxt      = DONE;
          frame_done_nxt = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_nxt      = DONE;
          frame_done_nxt = 1'b1;
          err_nxt        = 1'b1;
        end else begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state, counters and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      en_brch     <= 1'b0;
      sym_rx      <= 2'b00;
      tb_start    <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift       <= shift_nxt;
      cnt         <= cnt_nxt;
      to_cnt      <= to_nxt;
      en_brch     <= en_brch_nxt;
      sym_rx      <= sym_rx_nxt;
      tb_start    <= tb_start_nxt;
      frame_done  <= frame_done_nxt;
      err_timeout <= err_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  // ACS enable and trellis index trail the branch-metric enable by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_acs  <= 1'b0;
      sym_idx <= '0;
    end else begin
      en_acs <= en_brch;
      if (en_brch) begin
        sym_idx <= cnt;
      end else begin
        sym_idx <= sym_idx;
      end
    end
  end

endmodule

// File: doc/vit_seq_ctrl.md
VIT_SEQ_CTRL -- requirements
Module: vit_seq_ctrl

Interface
REQ-001 Parameter FRAME_SYMS, default 512, meaning 2-bit symbols per frame; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter TB_TIMEOUT, default 4096, meaning max cycles to wait for tb_done.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_word holds a valid received word.
REQ-006 in_ready  output  1  controller accepts in_word this cycle; transfer when in_valid&&in_ready.
REQ-007 in_word  input  16  eight 2-bit symbols, bits [15:14] first, [1:0] last.
REQ-008 en_brch  output  1  branch-metric enable, one symbol per asserted cycle.
REQ-009 sym_rx  output  2  symbol presented to branch-metric unit, valid when en_brch=1.
REQ-010 en_acs  output  1  add-compare-select enable, aligned with registered Hamming distances.
REQ-011 sym_idx  output  clog2(FRAME_SYMS)  trellis step of current en_acs.
REQ-012 tb_start  output  1  one-cycle pulse starting traceback.
REQ-013 tb_done  input  1  traceback complete, sampled only in state TB.
REQ-014 frame_done  output  1  one-cycle pulse, frame finished.
REQ-015 err_timeout  output  1  sticky: traceback exceeded TB_TIMEOUT.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, BRCH, WAIT, FLUSH, TB, DONE, encoded one-hot or binary at implementer choice.
REQ-018 IDLE: in_ready=1, en_brch=0; accepted word loads 16-bit shift register, clears symbol counter and err_timeout, next state BRCH.
REQ-019 BRCH: en_brch=1, sym_rx=shift[15:14], shift left by 2 each cycle, symbol counter +1 each cycle.
REQ-020 In BRCH in_ready SHALL be 1 only on the 8th symbol cycle of a word and only if the frame needs more symbols, so back-to-back words yield no en_brch bubble.
REQ-021 8th symbol with word accepted same cycle: reload shift register, stay BRCH.
REQ-022 8th symbol, more symbols needed, no word: go WAIT; WAIT holds en_brch=0, in_ready=1, returns to BRCH on acceptance.
REQ-023 Symbol FRAME_SYMS-1 issued: go FLUSH; in_ready=0 from then until IDLE; no word accepted mid-frame beyond FRAME_SYMS/8 words.
REQ-024 en_acs SHALL equal en_brch delayed by exactly 1 cycle; sym_idx SHALL equal the counter value of that symbol, delayed 1 cycle, range 0..FRAME_SYMS-1, no wrap within frame.
REQ-025 FLUSH lasts 1 cycle (last en_acs); then TB with tb_start=1 in first TB cycle only.
REQ-026 TB: timeout counter counts from tb_start cycle; tb_done in the tb_start cycle SHALL be ignored; tb_done=1 later -> DONE.
REQ-027 Timeout counter reaching TB_TIMEOUT-1 without tb_done: set err_timeout, go DONE; if both occur same cycle, tb_done wins, err_timeout stays 0.
REQ-028 DONE: frame_done=1 for 1 cycle, next state IDLE; next frame may begin the following cycle.
REQ-029 All outputs SHALL be registered except in_ready, which may be combinational from state and counter only (never from in_valid).

Reset
REQ-030 rst=1 asynchronously forces IDLE; en_brch, sym_rx, en_acs, sym_idx, tb_start, frame_done, err_timeout, busy = 0; counters and shift register = 0.
REQ-031 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-032 Reset mid-frame (any state) SHALL abandon the frame with no frame_done and no tb_start pulse afterwards.

Verification
REQ-033 FRAME_SYMS=16, words 16'hE41B,16'h1BE4 back-to-back -> en_brch 16 consecutive cycles, sym_rx 3,2,1,0,0,1,2,3,0,1,2,3,3,2,1,0; en_acs same pattern 1 cycle later, sym_idx 0..15.
REQ-034 Second word delayed 5 cycles -> exactly 5 en_brch=0 cycles between symbol 7 and 8 in WAIT; sym_idx continuous 7->8.
REQ-035 tb_done returned 3 cycles after tb_start -> frame_done pulses 1 cycle after tb_done, err_timeout=0, busy falls next cycle.
REQ-036 TB_TIMEOUT=8, tb_done never -> err_timeout=1 after 8 TB cycles, frame_done pulse, err_timeout held until next frame's first word accepted.
REQ-037 rst asserted during symbol 5 of frame -> all outputs 0 within same cycle, no further en_acs/tb_start; new frame after release starts sym_idx at 0.
REQ-038 in_valid held high continuously across FRAME_SYMS boundary -> exactly FRAME_SYMS/8 words accepted per frame, in_ready=0 from FLUSH through DONE.
